// File: rtl/mem_arb_pkg.sv
// Shared types, widths and slice helpers for the memory bus arbiter.
`ifndef MEM_ARB_PKG_SV
`define MEM_ARB_PKG_SV

// Select slice idx of a packed per-requester bus whose lanes are w bits wide.
`define MEM_ARB_SLICE(bus, idx, w) bus[32'(idx) * (w) +: (w)]

package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } arb_state_e;

    // Timer width able to hold 0 .. cycles-1.
    function automatic int unsigned timer_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`endif

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, or the
// lock holder alone when a lock is active.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               lock_active,
    output logic               any_grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Scan last_grant+1 .. last_grant+NUM_REQ with explicit wrap (NUM_REQ need not be a power of two).
    always_comb begin
        int unsigned cand;
        cand      = 0;
        any_grant = 1'b0;
        grant_idx = last_grant;
        if (lock_active) begin
            any_grant = req[last_grant];
        end else begin
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                cand = 32'(last_grant) + off;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!any_grant && req[IDX_W'(cand)]) begin
                    any_grant = 1'b1;
                    grant_idx = IDX_W'(cand);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory bus among NUM_REQ requesters,
// with AMO lock and per-transaction timeout fault.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 3,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*MASK_W-1:0] req_wmask,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_fault,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      mem_valid,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [MASK_W-1:0]         mem_wmask,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    localparam int unsigned TIMER_W = timer_w(TIMEOUT_CYCLES);

    arb_state_e           state, state_nxt;
    logic [IDX_W-1:0]     last_grant, last_grant_nxt;
    logic                 lock_active, lock_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic [IDX_W-1:0]     grant_nxt;
    logic                 mem_valid_nxt;
    logic [ADDR_W-1:0]    mem_addr_nxt;
    logic [DATA_W-1:0]    mem_wdata_nxt;
    logic [MASK_W-1:0]    mem_wmask_nxt;
    logic [NUM_REQ-1:0]   req_ready_nxt, req_fault_nxt;
    logic [DATA_W-1:0]    req_rdata_nxt;
    logic                 pick_lock;
    logic                 any_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   owner_onehot;

    // A lock only restricts arbitration while its holder is still requesting.
    assign pick_lock    = lock_active & req_valid[last_grant];
    assign owner_onehot = NUM_REQ'(1) << grant_id;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req         (req_valid),
        .last_grant  (last_grant),
        .lock_active (pick_lock),
        .any_grant   (any_grant),
        .grant_idx   (pick_idx)
    );

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        lock_nxt       = lock_active;
        timer_nxt      = '0;
        grant_nxt      = grant_id;
        mem_valid_nxt  = 1'b0;
        mem_addr_nxt   = '0;
        mem_wdata_nxt  = '0;
        mem_wmask_nxt  = '0;
        req_ready_nxt  = '0;
        req_fault_nxt  = '0;
        req_rdata_nxt  = '0;

        case (state)
            IDLE: begin
                if (lock_active && !req_valid[last_grant]) begin
                    lock_nxt = 1'b0;
                end
                if (any_grant) begin
                    state_nxt     = BUSY;
                    grant_nxt     = pick_idx;
                    mem_valid_nxt = 1'b1;
                    mem_addr_nxt  = `MEM_ARB_SLICE(req_addr, pick_idx, ADDR_W);
                    mem_wdata_nxt = `MEM_ARB_SLICE(req_wdata, pick_idx, DATA_W);
                    mem_wmask_nxt = `MEM_ARB_SLICE(req_wmask, pick_idx, MASK_W);
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt     = DONE;
                    req_ready_nxt = owner_onehot;
                    req_rdata_nxt = mem_rdata;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt     = FAULT;
                    req_ready_nxt = owner_onehot;
                    req_fault_nxt = owner_onehot;
                end else begin
                    timer_nxt     = timer + TIMER_W'(1);
                    mem_valid_nxt = 1'b1;
                    mem_addr_nxt  = mem_addr;
                    mem_wdata_nxt = mem_wdata;
                    mem_wmask_nxt = mem_wmask;
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                last_grant_nxt = grant_id;
                lock_nxt       = req_lock[grant_id];
            end
            FAULT: begin
                state_nxt      = IDLE;
                last_grant_nxt = grant_id;
                lock_nxt       = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any bus transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            lock_active <= 1'b0;
            timer       <= '0;
            grant_id    <= '0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
            req_ready   <= '0;
            req_fault   <= '0;
            req_rdata   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            lock_active <= lock_nxt;
            timer       <= timer_nxt;
            grant_id    <= grant_nxt;
            mem_valid   <= mem_valid_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            mem_wmask   <= mem_wmask_nxt;
            req_ready   <= req_ready_nxt;
            req_fault   <= req_fault_nxt;
            req_rdata   <= req_rdata_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single native memory bus (mem_valid/mem_ready) between up to NUM_REQ requesters: the core's fetch/data port, the SV32 page-table walker, and one spare (e.g. DMA).
- Sits between the requesters and the memory/peripheral interconnect.
- Provides round-robin arbitration, with a lock for AMO read-modify-write sequences.
- A per-transaction timeout converts a hung access into a bus fault that the core raises as access_fault.

Parameters:
- NUM_REQ, 3: number of requesters, 2..8.
- TIMEOUT_CYCLES, 1024: max cycles in BUSY before fault, >=2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester request, held until its req_ready
- req_lock  in  NUM_REQ  keep grant after completion (AMO/LR-SC)
- req_addr  in  NUM_REQ*32  packed addresses, slice i = requester i
- req_wdata  in  NUM_REQ*32  packed write data
- req_wmask  in  NUM_REQ*4  packed byte strobes, 0 = read
- req_ready  out  NUM_REQ  one-cycle completion pulse
- req_fault  out  NUM_REQ  one-cycle timeout flag, coincident with req_ready
- req_rdata  out  32  read data, valid with req_ready
- mem_valid  out  1  bus request
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_wmask  out  4  bus byte strobes
- mem_ready  in  1  bus completion
- mem_rdata  in  32  bus read data
- grant_id  out  $clog2(NUM_REQ)  current owner
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, priority over everything):
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first; lock_active = 0; timer = 0.
  - All outputs 0.
  - An in-flight bus transaction is abandoned; mem_valid is 0 after the edge.
- IDLE:
  - If any eligible req_valid, pick a winner and go to BUSY.
  - At the edge, register grant_id and latch addr/wdata/wmask from the winner's slice.
  - Winner selection: first set bit scanning from last_grant+1 with wrap-around.
  - If lock_active, only last_grant is eligible; the others wait even if valid.
- BUSY:
  - mem_valid = 1; mem_* driven from latched registers, stable until completion.
  - timer increments each cycle.
  - mem_ready = 1: capture mem_rdata, go to DONE.
  - timer == TIMEOUT_CYCLES-1 without mem_ready: go to FAULT.
  - mem_ready on that same cycle wins, so the result is DONE.
- DONE:
  - req_ready[grant_id] = 1 for one cycle; req_rdata = captured data.
  - last_grant = grant_id; lock_active = req_lock[grant_id] sampled this cycle.
  - Go to IDLE.
- FAULT:
  - Same as DONE, plus req_fault[grant_id] = 1 and req_rdata = 0.
  - lock_active is cleared.
- Latency: req_valid seen in cycle 0 gives mem_valid in cycle 1. mem_ready in cycle k gives req_ready in cycle k+1. Minimum is 3 cycles.
- Back-to-back: IDLE evaluates the next request the cycle after DONE. Bus utilisation is therefore at most 1 transaction per 3 cycles.
- Other boundary cases:
  - mem_ready outside BUSY is ignored.
  - Requester dropping req_valid mid-transaction: the transaction still completes and the ready pulse is still issued.
  - Lock holder drops req_valid while lock_active: clear lock_active in IDLE and arbitrate normally the same cycle.
  - NUM_REQ not a power of two: wrap goes from NUM_REQ-1 to 0; grant_id never exceeds NUM_REQ-1.
- mem_* outputs are 0 when not in BUSY.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, DONE, FAULT}, 2 bits.
  - TIMER_W = $clog2(TIMEOUT_CYCLES) function/constant.
  - Slice helper macros for the packed request buses.
- Sub-module rr_picker, purely combinational:
  - Inputs: request vector, last_grant, lock_active.
  - Outputs: any_grant, grant index.
  - Reused by the interrupt-controller work.

Test Plan:
- Single request: req_valid=001, addr 0x8000_0010, wmask 0, mem_ready in cycle 1 with rdata 0xDEADBEEF -> mem_valid in cycle 1, req_ready=001 and req_rdata=0xDEADBEEF in cycle 2, busy low in cycle 3.
- Round-robin fairness: req_valid=111 held continuously, zero-wait memory -> grant order 0,1,2,0,1,2, one grant per 3 cycles, no starvation.
- Lock: requester 1 asserts req_lock during its DONE while 0 and 2 are pending -> next grant is 1 again; grant goes to 2 after 1 drops the lock.
- Timeout: TIMEOUT_CYCLES=16, mem_ready never asserted -> req_ready[g]=1, req_fault[g]=1, req_rdata=0 on the cycle after timer=15; mem_valid low; lock cleared.
- Boundary: mem_ready exactly at timer=TIMEOUT_CYCLES-1 -> DONE with valid data, no fault. Separately, reset asserted mid-BUSY -> next cycle state IDLE, all outputs 0, and requester 0 wins the following arbitration.
